hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline stall/flush scheduler for the 5-stage CPU. It sits beside the EXE-stage forwarding unit and decides, every cycle, whether the front end freezes, a bubble enters ID/EXE, the wrong-path instruction in IF/ID is flushed, or the whole pipeline freezes while a data-memory access completes. It also keeps saturating stall counters and a sticky memory-timeout flag for debug.

## Interface
- `MEM_TIMEOUT`, 255: max freeze cycles allowed for one memory access before the timeout flag sets.
- `CNT_W`, 16: width of the stall counters.
- `clk`  in  1  single clock; everything updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `src1_ID`, `src2_ID`  in  `REG_FILE_ADDR_LEN` (5)  source registers of the instruction in ID.
- `two_src_ID`  in  1  `src2_ID` is actually read.
- `dest_EXE`, `WB_EN_EXE`, `MEM_R_EN_EXE`  in  5/1/1  destination, write-back enable and load flag in EXE.
- `dest_MEM`, `WB_EN_MEM`  in  5/1  destination and write-back enable in MEM.
- `forward_en`  in  1  forwarding unit active.
- `branch_taken`  in  1  taken branch resolved in EXE.
- `mem_req`  in  1  MEM stage is issuing a data-memory read or write.
- `mem_ready`  in  1  data memory completes the current access this cycle.
- `clr_cnt`  in  1  synchronous clear of both counters.
- `freeze_front`  out  1  hold PC and IF/ID.
- `bubble_EXE`  out  1  load NOP into ID/EXE.
- `flush_ID`  out  1  load NOP into IF/ID.
- `freeze_back`  out  1  hold PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB.
- `hz_stall_cnt`  out  `CNT_W`  hazard stall cycles, saturating.
- `mem_stall_cnt`  out  `CNT_W`  memory freeze cycles, saturating.
- `mem_timeout`  out  1  sticky; cleared only by `rst`.

## Operation
- **Register 0.** A source equal to 0 never matches anything.
- **Source match.** A source "matches X" when it equals X. For `src2_ID`, this applies only if `two_src_ID`=1.
- **hazard.**
  - If `forward_en`=1: `MEM_R_EN_EXE` && `WB_EN_EXE` && a source matches `dest_EXE` (load-use).
  - If `forward_en`=0: (`WB_EN_EXE` && match `dest_EXE`) || (`WB_EN_MEM` && match `dest_MEM`).
- **FSM states:**
  - RUN:
    - `mem_req` && !`mem_ready`: `freeze_back`=1, go to WAIT, `wait_cnt`←1.
    - Otherwise stay in RUN.
  - WAIT:
    - `freeze_back`=1 while !`mem_ready`, and `wait_cnt` increments (saturating).
    - On `mem_ready`=1: `freeze_back`=0 that same cycle (the pipeline advances) and go to RUN.
    - When `wait_cnt`≥`MEM_TIMEOUT` and !`mem_ready`: set `mem_timeout`. The freeze continues.
- **Output priority** (evaluated each cycle):
  - `freeze_back`=1 forces `freeze_front`=1, `bubble_EXE`=0, `flush_ID`=0.
  - Else if `branch_taken`: `flush_ID`=1, `bubble_EXE`=1, `freeze_front`=0. The hazard is ignored because the ID instruction is on the wrong path.
  - Else if hazard: `freeze_front`=1, `bubble_EXE`=1.
  - Else all outputs are 0.
- **Counters.**
  - `hz_stall_cnt` increments in cycles where `freeze_front`=1 && `freeze_back`=0.
  - `mem_stall_cnt` increments in cycles where `freeze_back`=1.
  - Both hold at 2^`CNT_W`−1.
  - `clr_cnt` has priority over an increment in the same cycle.

## Timing
- **Decision outputs.** All four decision outputs are Mealy outputs, combinational from the current state and the current inputs. There is zero-cycle latency from a hazard to the stall.
- **Registered state.** State, `wait_cnt`, the counters and `mem_timeout` are registered.
- **Reset.** Reset, even mid-WAIT, forces:
  - state=RUN, `wait_cnt`=0, both counters=0, `mem_timeout`=0.
  - With idle inputs, every output is 0.
- **Load-use.** A load-use hazard produces exactly one stall cycle. Next cycle the load is in MEM, no hazard exists, and the stall releases.
- **No forwarding.** With `forward_en`=0, a dependent instruction stalls 1–2 cycles until the producer leaves MEM.
- **One-cycle access.** `mem_req` && `mem_ready` in the same cycle in RUN: no freeze, and state stays RUN.
- **Hazard during freeze.** A hazard that is present during a memory freeze is re-evaluated once the freeze releases.
- **`forward_en` toggling** takes effect in the same cycle.

## Test plan
- **Load-use.** Load r3 in EXE (`MEM_R_EN_EXE`=1, `WB_EN_EXE`=1, `dest_EXE`=3), `src1_ID`=3, `forward_en`=1.
  - Expect `freeze_front`=1 and `bubble_EXE`=1 for exactly one cycle.
  - Expect `hz_stall_cnt`=1.
  - Repeat with `dest_EXE`=0: no stall.
- **No-forward RAW.** `forward_en`=0, ADD writing r5 in EXE, `src2_ID`=5.
  - With `two_src_ID`=1: stall for 2 cycles as the producer moves EXE→MEM.
  - With `two_src_ID`=0: no stall.
- **Memory wait.** `mem_req`=1 with `mem_ready` low for 4 cycles, then high.
  - Expect `freeze_back`=1 for 4 cycles and 0 in the ready cycle.
  - Expect `mem_stall_cnt`=4.
  - A hazard raised during the wait gives `bubble_EXE`=0.
- **Branch vs hazard.** `branch_taken`=1 together with a load-use hazard.
  - Expect `flush_ID`=1, `bubble_EXE`=1, `freeze_front`=0.
  - Same inputs while `freeze_back`=1: `flush_ID`=0.
- **Timeout.** `MEM_TIMEOUT`=3, `mem_ready` held low.
  - Expect `mem_timeout` to rise when `wait_cnt` reaches 3 and stay set after `mem_ready`.
  - `rst` asserted mid-WAIT clears it, returns to RUN and deasserts `freeze_back` asynchronously.
- **Counter saturation.** `CNT_W`=4 with 20 hazard cycles: `hz_stall_cnt`=15.
  - `clr_cnt` asserted in an increment cycle leaves the count at 0.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline hazard/stall scheduler signal bundle
interface hazard_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic [ADDR_W-1:0] src1_ID;
    logic [ADDR_W-1:0] src2_ID;
    logic              two_src_ID;
    logic [ADDR_W-1:0] dest_EXE;
    logic              WB_EN_EXE;
    logic              MEM_R_EN_EXE;
    logic [ADDR_W-1:0] dest_MEM;
    logic              WB_EN_MEM;
    logic              forward_en;
    logic              branch_taken;
    logic              mem_req;
    logic              mem_ready;
    logic              clr_cnt;
    logic              freeze_front;
    logic              bubble_EXE;
    logic              flush_ID;
    logic              freeze_back;
    logic [CNT_W-1:0]  hz_stall_cnt;
    logic [CNT_W-1:0]  mem_stall_cnt;
    logic              mem_timeout;

    modport master (
        output src1_ID, src2_ID, two_src_ID, dest_EXE, WB_EN_EXE, MEM_R_EN_EXE,
               dest_MEM, WB_EN_MEM, forward_en, branch_taken, mem_req, mem_ready, clr_cnt,
        input  freeze_front, bubble_EXE, flush_ID, freeze_back,
               hz_stall_cnt, mem_stall_cnt, mem_timeout
    );

    modport slave (
        input  src1_ID, src2_ID, two_src_ID, dest_EXE, WB_EN_EXE, MEM_R_EN_EXE,
               dest_MEM, WB_EN_MEM, forward_en, branch_taken, mem_req, mem_ready, clr_cnt,
        output freeze_front, bubble_EXE, flush_ID, freeze_back,
               hz_stall_cnt, mem_stall_cnt, mem_timeout
    );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush scheduler with memory-wait FSM and debug counters
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave bus
);
    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic {S_RUN, S_WAIT} state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  hz_cnt;
    logic [CNT_W-1:0]  mem_cnt;
    logic              timeout;

    logic m1_exe, m2_exe, m1_mem, m2_mem, hazard;
    logic fb, ff, bub, flush;

    always_comb begin
        m1_exe = (bus.src1_ID != '0) && (bus.src1_ID == bus.dest_EXE);
        m2_exe = bus.two_src_ID && (bus.src2_ID != '0) && (bus.src2_ID == bus.dest_EXE);
        m1_mem = (bus.src1_ID != '0) && (bus.src1_ID == bus.dest_MEM);
        m2_mem = bus.two_src_ID && (bus.src2_ID != '0) && (bus.src2_ID == bus.dest_MEM);
        if (bus.forward_en)
            hazard = bus.MEM_R_EN_EXE && bus.WB_EN_EXE && (m1_exe || m2_exe);
        else
            hazard = (bus.WB_EN_EXE && (m1_exe || m2_exe)) || (bus.WB_EN_MEM && (m1_mem || m2_mem));

        // Gated by rst so the back-end freeze drops the instant reset is applied.
        fb    = !rst && !bus.mem_ready && ((state == S_WAIT) || bus.mem_req);
        ff    = 1'b0;
        bub   = 1'b0;
        flush = 1'b0;
        if (fb) begin
            ff = 1'b1;
        end else if (bus.branch_taken) begin
            bub   = 1'b1;
            flush = 1'b1;
        end else if (hazard) begin
            ff  = 1'b1;
            bub = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_RUN;
            wait_cnt <= '0;
            hz_cnt   <= '0;
            mem_cnt  <= '0;
            timeout  <= 1'b0;
        end else begin
            if (bus.clr_cnt) begin
                hz_cnt  <= '0;
                mem_cnt <= '0;
            end else begin
                if (ff && !fb && (hz_cnt != '1))
                    hz_cnt <= hz_cnt + CNT_ONE;
                if (fb && (mem_cnt != '1))
                    mem_cnt <= mem_cnt + CNT_ONE;
            end

            case (state)
                S_RUN: begin
                    if (bus.mem_req && !bus.mem_ready) begin
                        state    <= S_WAIT;
                        wait_cnt <= WAIT_ONE;
                    end
                end
                S_WAIT: begin
                    if (bus.mem_ready) begin
                        state <= S_RUN;
                    end else begin
                        if (wait_cnt >= WAIT_MAX)
                            timeout <= 1'b1;
                        // Saturates at the threshold; only the comparison above matters.
                        if (wait_cnt < WAIT_MAX)
                            wait_cnt <= wait_cnt + WAIT_ONE;
                    end
                end
                default: state <= S_RUN;
            endcase
        end
    end

    assign bus.freeze_back   = fb;
    assign bus.freeze_front  = ff;
    assign bus.bubble_EXE    = bub;
    assign bus.flush_ID      = flush;
    assign bus.hz_stall_cnt  = hz_cnt;
    assign bus.mem_stall_cnt = mem_cnt;
    assign bus.mem_timeout   = timeout;
endmodule
